// File: rtl/spi_fpga_pkg.sv
// spi_fpga_pkg: shared FSM state type and timing/width helpers for the SPI master
package spi_fpga_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  localparam int DEF_HALF = 2;
  localparam int DEF_HALF_W = $clog2(DEF_HALF) + 1;
  localparam int DEF_EDGE_W = $clog2(2 * 8) + 1;
  function automatic int clks_per_half(input int freq, input int bps);
    return freq / (2 * bps);
  endfunction
  function automatic int half_cnt_w(input int h);
    return $clog2(h) + 1;
  endfunction
  function automatic int edge_cnt_w(input int pack_len);
    return $clog2(2 * pack_len) + 1;
  endfunction
endpackage

// File: rtl/spi_fpga_clk_div.sv
// spi_fpga_clk_div: emits a one-cycle tick every H enabled clocks, cleared synchronously
module spi_fpga_clk_div #(
  parameter int H = 2,
  parameter int W = $clog2(H) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(H - 1);
  // count enabled clocks, restarting after every tick
  always_ff @(posedge clk)
    cnt <= (rst || clr || tick) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/spi_fpga_master.sv
// spi_fpga_master: SPI master, one word per launch edge; SPI_FPGA_MASTER_LOOPBACK_EN feeds MOSI back into the receiver
module spi_fpga_master
  import spi_fpga_pkg::*;
#(
  parameter int BIT_PER_SECOND = 12500000,
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int PACK_LENGTH = 8,
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0,
  parameter int PACK_BIT_SEQUENCE_TRANSMIT = 1,
  parameter int PACK_BIT_SEQUENCE_RECEIVE = 1
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET,
  input  logic                   IN_LAUNCH,
  input  logic [PACK_LENGTH-1:0] IN_DATA,
  input  logic                   IN_MISO,
  output logic                   OUT_MOSI,
  output logic                   OUT_CS,
  output logic                   OUT_SCLK,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
  output logic                   OUT_ACTION_DONE
);
  localparam int H = clks_per_half(CLOCK_FREQUENCY, BIT_PER_SECOND);
  localparam int EW = edge_cnt_w(PACK_LENGTH);
  localparam logic [EW-1:0] LAST = EW'(2 * PACK_LENGTH);
  localparam logic [EW-1:0] LAST_M1 = EW'(2 * PACK_LENGTH - 1);
  localparam logic MSB_TX = PACK_BIT_SEQUENCE_TRANSMIT != 0;
  localparam logic MSB_RX = PACK_BIT_SEQUENCE_RECEIVE != 0;
  state_t state, state_n;
  logic launch_d, start, tick, edge_ev, lead, advance, sample, rx_bit, tx_bit;
  logic [EW-1:0] edges;
  logic [PACK_LENGTH-1:0] tx, rx, tx_shift, in_shift;
  spi_fpga_clk_div #(.H(H), .W(half_cnt_w(H))) u_div (
    .clk (IN_CLOCK),
    .rst (IN_RESET),
    .en  (state == SETUP || state == SHIFT || state == HOLD),
    .clr (state == IDLE || state == DONE),
    .tick(tick)
  );
`ifdef SPI_FPGA_MASTER_LOOPBACK_EN
  assign rx_bit = OUT_MOSI;
`else
  assign rx_bit = IN_MISO;
`endif
  // state register
  always_ff @(posedge IN_CLOCK)
    state <= IN_RESET ? IDLE : state_n;
  // next state and per-edge shift decisions; edges holds the number of SCLK edges already issued
  always_comb begin
    start = IN_LAUNCH && !launch_d && state == IDLE;
    state_n = state == IDLE  ? (start ? SETUP : IDLE)
            : state == SETUP ? (tick ? SHIFT : SETUP)
            : state == SHIFT ? ((tick && edges == LAST) ? HOLD : SHIFT)
            : state == HOLD  ? (tick ? DONE : HOLD)
            : IDLE;
    edge_ev = tick && (state == SETUP || (state == SHIFT && edges != LAST));
    lead = !edges[0];
    advance = edge_ev && (CPHA ? lead : (!lead && edges != LAST_M1));
    sample = edge_ev && (CPHA ? !lead : lead);
    tx_bit = MSB_TX ? tx[PACK_LENGTH-1] : tx[0];
    tx_shift = MSB_TX ? tx << 1 : tx >> 1;
    in_shift = MSB_TX ? IN_DATA << 1 : IN_DATA >> 1;
  end
  // datapath: SCLK, chip select, shifters and registered outputs
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      launch_d <= 1'b0;
      edges <= '0;
      tx <= '0;
      rx <= '0;
      OUT_SCLK <= CPOL;
      OUT_MOSI <= 1'b0;
      OUT_CS <= 1'b1;
      OUT_RECEIVE_DATA <= '0;
      OUT_ACTION_DONE <= 1'b0;
    end else begin
      launch_d <= IN_LAUNCH;
      OUT_CS <= !(state_n == SETUP || state_n == SHIFT || state_n == HOLD);
      OUT_ACTION_DONE <= state_n == DONE;
      if (start) begin
        edges <= '0;
        rx <= '0;
        tx <= CPHA ? IN_DATA : in_shift;
        OUT_MOSI <= CPHA ? 1'b0 : IN_DATA[MSB_TX ? PACK_LENGTH-1 : 0];
      end
      if (edge_ev) begin
        OUT_SCLK <= !OUT_SCLK;
        edges <= edges + 1'b1;
      end
      if (advance) begin
        OUT_MOSI <= tx_bit;
        tx <= tx_shift;
      end
      if (sample)
        rx <= MSB_RX ? {rx[PACK_LENGTH-2:0], rx_bit} : {rx_bit, rx[PACK_LENGTH-1:1]};
      if (state_n == DONE) begin
        OUT_MOSI <= 1'b0;
        OUT_RECEIVE_DATA <= rx;
      end
    end
  end
endmodule

// File: tb/tb_spi_fpga_master.sv
// tb_spi_fpga_master: directed checks of mode 0, mode 3 and LSB-first masters against a behavioural slave
module tb_spi_fpga_master;
`ifdef SPI_FPGA_MASTER_LOOPBACK_EN
  localparam logic LB = 1'b1;
`else
  localparam logic LB = 1'b0;
`endif
  localparam logic [2:0] CPOL_A = 3'b010;
  localparam logic [2:0] CPHA_A = 3'b010;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic [2:0] launch = '0, miso = '0;
  logic [2:0] cs, sclk, mosi, done;
  logic [7:0] rxd [3];
  logic [7:0] sword [3];
  logic [7:0] mosi_log [3];
  logic [2:0] cs_p = '1, sclk_p = 3'b010, mosi_p = '0;
  int cyc = 0, checks = 0, failures = 0;
  int idx [3], edge_n [3], cs_low [3], last_lead [3], period [3], dcnt [3], bad [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_fpga_master u0 (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_LAUNCH(launch[0]), .IN_DATA(data), .IN_MISO(miso[0]),
    .OUT_MOSI(mosi[0]), .OUT_CS(cs[0]), .OUT_SCLK(sclk[0]), .OUT_RECEIVE_DATA(rxd[0]), .OUT_ACTION_DONE(done[0]));
  spi_fpga_master #(.CPOL(1'b1), .CPHA(1'b1)) u3 (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_LAUNCH(launch[1]), .IN_DATA(data), .IN_MISO(miso[1]),
    .OUT_MOSI(mosi[1]), .OUT_CS(cs[1]), .OUT_SCLK(sclk[1]), .OUT_RECEIVE_DATA(rxd[1]), .OUT_ACTION_DONE(done[1]));
  spi_fpga_master #(.PACK_BIT_SEQUENCE_TRANSMIT(0), .PACK_BIT_SEQUENCE_RECEIVE(0)) ul (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_LAUNCH(launch[2]), .IN_DATA(data), .IN_MISO(miso[2]),
    .OUT_MOSI(mosi[2]), .OUT_CS(cs[2]), .OUT_SCLK(sclk[2]), .OUT_RECEIVE_DATA(rxd[2]), .OUT_ACTION_DONE(done[2]));

  initial for (int i = 0; i < 3; i++) begin
    idx[i] = 8; edge_n[i] = 0; cs_low[i] = 0; last_lead[i] = 0; period[i] = 0;
    dcnt[i] = 0; bad[i] = 0; sword[i] = 8'h00; mosi_log[i] = 8'h00;
  end

  // bus monitor and behavioural slave, evaluated away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic chg, ld;
      chg = sclk[i] != sclk_p[i];
      ld = sclk_p[i] == CPOL_A[i];
      if (done[i]) dcnt[i]++;
      if (!cs[i]) begin
        if (cs_p[i]) begin
          cs_low[i] = 0; edge_n[i] = 0; last_lead[i] = 0;
          idx[i] = CPHA_A[i] ? -1 : 0;
        end
        cs_low[i]++;
        if (chg) begin
          edge_n[i]++;
          if (ld) begin
            if (last_lead[i] != 0) period[i] = cyc - last_lead[i];
            last_lead[i] = cyc;
          end
          if (ld != CPHA_A[i]) mosi_log[i] = {mosi_log[i][6:0], mosi[i]};
          else idx[i]++;
        end
        if (CPHA_A[i] && mosi[i] != mosi_p[i] && !(chg && ld)) bad[i]++;
      end
      miso[i] = (!cs[i] && idx[i] >= 0 && idx[i] < 8) ? sword[i][7 - idx[i]] : 1'b0;
      cs_p[i] = cs[i]; sclk_p[i] = sclk[i]; mosi_p[i] = mosi[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int i, input logic [7:0] d, input logic [7:0] sw, input int hold);
    int d0, n;
    d0 = dcnt[i]; n = 0;
    sword[i] = sw; data = d;
    @(negedge clk) launch[i] = 1'b1;
    repeat (hold) @(negedge clk);
    launch[i] = 1'b0;
    while (dcnt[i] == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 32'(n < 200), 32'd1);
    data = ~d;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, d0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cs", 32'(cs[0]), 32'd1);
    chk("rst_sclk0", 32'(sclk[0]), 32'd0);
    chk("rst_mosi", 32'(mosi[0]), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rxd[0]), 32'd0);
    chk("rst_sclk3", 32'(sclk[1]), 32'd1);
    chk("rst_cs_lsb", 32'(cs[2]), 32'd1);

    run(0, 8'hEA, 8'h53, 60);
    chk("m0_mosi", 32'(mosi_log[0]), 32'hEA);
    chk("m0_rx", 32'(rxd[0]), LB ? 32'hEA : 32'h53);
    chk("m0_period", 32'(period[0]), 32'd4);
    chk("m0_cs_low", 32'(cs_low[0]), 32'd36);
    repeat (40) @(negedge clk);
    chk("m0_one_frame", 32'(dcnt[0]), 32'd1);

    run(0, 8'h5C, 8'hA1, 1);
    chk("m0_rx2", 32'(rxd[0]), LB ? 32'h5C : 32'hA1);
    chk("m0_mosi2", 32'(mosi_log[0]), 32'h5C);
    chk("m0_two_frames", 32'(dcnt[0]), 32'd2);

    run(1, 8'hA5, 8'h3C, 1);
    chk("m3_mosi", 32'(mosi_log[1]), 32'hA5);
    chk("m3_rx", 32'(rxd[1]), LB ? 32'hA5 : 32'h3C);
    chk("m3_mosi_edges", 32'(bad[1]), 32'd0);
    chk("m3_sclk_idle", 32'(sclk[1]), 32'd1);
    chk("m3_cs_low", 32'(cs_low[1]), 32'd36);
    chk("m3_done", 32'(dcnt[1]), 32'd1);

    run(2, 8'hEA, 8'h53, 1);
    chk("lsb_mosi", 32'(mosi_log[2]), 32'h57);
    chk("lsb_rx", 32'(rxd[2]), LB ? 32'hEA : 32'hCA);

    run(0, 8'h96, 8'h53, 1);
    chk("lb_rx", 32'(rxd[0]), LB ? 32'h96 : 32'h53);

    d0 = dcnt[0]; n = 0;
    sword[0] = 8'hFF; data = 8'hFF;
    @(negedge clk) launch[0] = 1'b1;
    @(negedge clk) launch[0] = 1'b0;
    while (edge_n[0] < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_edge_wait", 32'(n < 100), 32'd1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("abort_cs", 32'(cs[0]), 32'd1);
    chk("abort_sclk", 32'(sclk[0]), 32'd0);
    chk("abort_mosi", 32'(mosi[0]), 32'd0);
    chk("abort_rx", 32'(rxd[0]), 32'd0);
    repeat (60) @(negedge clk);
    chk("abort_no_done", 32'(dcnt[0]), 32'(d0));
    chk("abort_idle_cs", 32'(cs[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
